// File: rtl/sc_rand_delay_timer_pkg.sv
// sc_randtimer_pkg: state encoding (IDLE/COUNT/DONE) and default parameters for sc_rand_delay_timer
package sc_randtimer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t COUNT = 2'd1;
  localparam state_t DONE = 2'd2;
  localparam int DEF_DATAWIDTH = 8;
  localparam int DEF_PRESCALE = 50000;
endpackage

// File: rtl/sc_rand_delay_timer_prescaler.sv
// sc_randtimer_prescaler: counts 0..PRESCALE-1 and wraps; ports clk, rst_n (async low), clear (sync zero), tick (high on the wrap cycle)
module sc_randtimer_prescaler
  import sc_randtimer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  logic [W-1:0] cnt;
  assign tick = !clear && cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sc_rand_delay_timer.sv
// sc_rand_delay_timer: random-length tick delay (clock, async low reset, random, start, abort -> busy, done pulse, count); SC_RANDTIMER_RETRIGGER_EN lets start recapture in COUNT
module sc_rand_delay_timer
  import sc_randtimer_pkg::*;
#(
  parameter int RANDTIMER_DATAWIDTH = DEF_DATAWIDTH,
  parameter int RANDTIMER_PRESCALE = DEF_PRESCALE
) (
  input  logic                           SC_RandTIMER_CLOCK_50,
  input  logic                           SC_RandTIMER_RESET_InLow,
  input  logic [RANDTIMER_DATAWIDTH-1:0] SC_RandTIMER_random_InBUS,
  input  logic                           SC_RandTIMER_start_In,
  input  logic                           SC_RandTIMER_abort_In,
  output logic                           SC_RandTIMER_busy_Out,
  output logic                           SC_RandTIMER_done_Out,
  output logic [RANDTIMER_DATAWIDTH-1:0] SC_RandTIMER_count_OutBUS
);
  localparam int W = RANDTIMER_DATAWIDTH;
  state_t state, nxt;
  logic [W-1:0] cnt, cnt_nxt, load;
  logic tick, capture, clear, abort;
  assign abort = SC_RandTIMER_abort_In;
  assign load = SC_RandTIMER_random_InBUS == '0 ? W'(1) : SC_RandTIMER_random_InBUS;
`ifdef SC_RANDTIMER_RETRIGGER_EN
  assign capture = SC_RandTIMER_start_In && !abort && (state == IDLE || state == COUNT);
`else
  assign capture = SC_RandTIMER_start_In && !abort && state == IDLE;
`endif
  assign clear = state != COUNT || capture || abort;
  sc_randtimer_prescaler #(.PRESCALE(RANDTIMER_PRESCALE)) u_prescaler (
    .clk  (SC_RandTIMER_CLOCK_50),
    .rst_n(SC_RandTIMER_RESET_InLow),
    .clear(clear),
    .tick (tick)
  );
  always_comb begin
    nxt = ((state != IDLE && state != COUNT) || abort) ? IDLE :
          capture ? COUNT :
          (state == COUNT && tick && cnt == W'(1)) ? DONE : state;
    cnt_nxt = (abort && state == COUNT) ? '0 :
              capture ? load :
              (state == COUNT && tick) ? cnt - 1'b1 : cnt;
  end
  always_ff @(posedge SC_RandTIMER_CLOCK_50 or negedge SC_RandTIMER_RESET_InLow)
    if (!SC_RandTIMER_RESET_InLow) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  assign SC_RandTIMER_busy_Out = state == COUNT;
  assign SC_RandTIMER_done_Out = state == DONE;
  assign SC_RandTIMER_count_OutBUS = cnt;
endmodule

// File: tb/tb_sc_rand_delay_timer.sv
// tb_sc_rand_delay_timer: table-driven vectors with a done-cycle scoreboard plus reset, abort and DONE-state corner sequences
module tb_sc_rand_delay_timer;
  localparam int P = 4;
`ifdef SC_RANDTIMER_RETRIGGER_EN
  localparam int RT = 1;
`else
  localparam int RT = 0;
`endif
  typedef struct {
    int rnd;
    int abort_k;
    int re_k;
    int re_rnd;
    int exp_done;
  } vec_t;
  logic clk = 0, rst_n = 1, start = 0, abort = 0;
  logic [7:0] rnd = 0;
  logic busy, done;
  logic [7:0] cnt;
  int pass = 0, total = 0;
  int sb[$];
  vec_t vecs[6];
  always #5 clk = ~clk;
  sc_rand_delay_timer #(.RANDTIMER_DATAWIDTH(8), .RANDTIMER_PRESCALE(P)) dut (
    .SC_RandTIMER_CLOCK_50    (clk),
    .SC_RandTIMER_RESET_InLow (rst_n),
    .SC_RandTIMER_random_InBUS(rnd),
    .SC_RandTIMER_start_In    (start),
    .SC_RandTIMER_abort_In    (abort),
    .SC_RandTIMER_busy_Out    (busy),
    .SC_RandTIMER_done_Out    (done),
    .SC_RandTIMER_count_OutBUS(cnt)
  );
  function automatic int outs();
    return int'({busy, done, cnt});
  endfunction
  function automatic int pack(int b, int d, int c);
    return (b << 9) | (d << 8) | c;
  endfunction
  function automatic int ld(int r);
    return r == 0 ? 1 : r;
  endfunction
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(vec_t v, int id);
    int first, pulses, b, n, j, eb, ed, ec;
    first = -1;
    pulses = 0;
    rnd = 8'(v.rnd);
    start = 1;
    sb.push_back(v.exp_done);
    step();
    start = 0;
    rnd = 8'hFF;
    for (int k = 0; k < 30; k++) begin
      b = 0;
      n = ld(v.rnd);
      if (RT != 0 && v.re_k != 0 && k >= v.re_k) begin
        b = v.re_k;
        n = ld(v.re_rnd);
      end
      j = k - b;
      if (v.abort_k != 0 && k >= v.abort_k) begin
        eb = 0;
        ed = 0;
        ec = 0;
      end else begin
        eb = j < n * P ? 1 : 0;
        ed = j == n * P ? 1 : 0;
        ec = j < n * P ? n - j / P : 0;
      end
      chk($sformatf("v%0d k%0d busy/done/count", id, k), outs(), pack(eb, ed, ec));
      if (done) begin
        pulses++;
        if (first < 0) first = k;
      end
      start = v.re_k != 0 && k == v.re_k - 1;
      rnd = start ? 8'(v.re_rnd) : 8'hFF;
      abort = v.abort_k != 0 && k == v.abort_k - 1;
      step();
    end
    start = 0;
    abort = 0;
    chk($sformatf("v%0d done_cycle", id), first, sb.pop_front());
    chk($sformatf("v%0d done_pulses", id), pulses, v.exp_done < 0 ? 0 : 1);
  endtask
  initial begin
    vecs[0] = '{rnd: 3, abort_k: 0, re_k: 0, re_rnd: 0, exp_done: 12};
    vecs[1] = '{rnd: 0, abort_k: 0, re_k: 0, re_rnd: 0, exp_done: 4};
    vecs[2] = '{rnd: 5, abort_k: 8, re_k: 0, re_rnd: 0, exp_done: -1};
    vecs[3] = '{rnd: 2, abort_k: 8, re_k: 0, re_rnd: 0, exp_done: -1};
    vecs[4] = '{rnd: 6, abort_k: 0, re_k: 8, re_rnd: 2, exp_done: RT != 0 ? 16 : 24};
    vecs[5] = '{rnd: 4, abort_k: 0, re_k: 0, re_rnd: 0, exp_done: 16};
    #2 rst_n = 0;
    #1 chk("reset_outputs", outs(), 0);
    step();
    step();
    rst_n = 1;
    chk("post_reset_idle", outs(), 0);
    foreach (vecs[i]) run_vec(vecs[i], i);
    rnd = 8'd9;
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("start_abort_idle k%0d busy/done", k), int'({busy, done}), 0);
      step();
    end
    rnd = 8'd1;
    start = 1;
    step();
    start = 0;
    for (int k = 1; k < 4; k++) step();
    step();
    chk("done_state_entry", outs(), pack(0, 1, 0));
    rnd = 8'd3;
    start = 1;
    step();
    start = 0;
    chk("start_in_done_ignored", outs(), pack(0, 0, 0));
    step();
    chk("start_in_done_stays_idle", outs(), pack(0, 0, 0));
    rnd = 8'd7;
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 6; k++) step();
    chk("mid_count_busy", int'(busy), 1);
    #2 rst_n = 0;
    #1 chk("async_reset_mid_count", outs(), 0);
    step();
    rst_n = 1;
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("after_reset k%0d", k), outs(), 0);
      step();
    end
    run_vec(vecs[0], 6);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/sc_rand_delay_timer.md
SC_RAND_DELAY_TIMER -- requirements
Module: sc_rand_delay_timer

Interface
REQ-001 Parameter RANDTIMER_DATAWIDTH, default 8, SHALL set the width of the random value and of the delay counter.
REQ-002 Parameter RANDTIMER_PRESCALE, default 50000, SHALL set the number of clock cycles per delay tick (1 ms at 50 MHz); legal range is 2 or more.
REQ-003 SC_RandTIMER_CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 SC_RandTIMER_RESET_InLow  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 SC_RandTIMER_random_InBUS  input  DATAWIDTH  SHALL carry the pseudo-random value from the upstream shift-register stage.
REQ-006 SC_RandTIMER_start_In  input  1  SHALL be a level-sampled start request, active-high.
REQ-007 SC_RandTIMER_abort_In  input  1  SHALL be an active-high cancel request.
REQ-008 SC_RandTIMER_busy_Out  output  1  SHALL be high while a delay is running.
REQ-009 SC_RandTIMER_done_Out  output  1  SHALL be a one-cycle pulse at delay expiry.
REQ-010 SC_RandTIMER_count_OutBUS  output  DATAWIDTH  SHALL expose the remaining tick count.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, COUNT, DONE.
REQ-012 In IDLE with start_In=1 and abort_In=0 at edge E0, the block SHALL capture random_InBUS into the counter, clear the prescaler, and enter COUNT.
REQ-013 A captured value of 0 SHALL be replaced by 1, so every delay is at least one tick.
REQ-014 In COUNT the prescaler SHALL count 0..PRESCALE-1 and wrap; each wrap is one tick.
REQ-015 At each tick the counter SHALL decrement by 1; the tick that takes it from 1 to 0 SHALL move the FSM to DONE.
REQ-016 For a loaded value N, the FSM SHALL enter DONE at edge E0+N*PRESCALE, and done_Out SHALL be high for exactly the following cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge; a start request in DONE SHALL be ignored.
REQ-018 busy_Out SHALL be high exactly while the FSM is in COUNT.
REQ-019 count_OutBUS SHALL show the counter value; it holds its last value in IDLE and shows 0 in DONE.
REQ-020 abort_In=1 in COUNT SHALL return the FSM to IDLE on the next edge, clear the counter and prescaler, and produce no done pulse.
REQ-021 abort_In and start_In both high in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-022 abort_In on the same edge as the final tick: abort SHALL win and no done pulse SHALL occur.
REQ-023 random_InBUS SHALL be sampled only at the capture edge; later changes SHALL NOT affect a running delay.

Reset
REQ-024 While RESET_InLow=0, the block SHALL immediately force state=IDLE, counter=0, prescaler=0, busy_Out=0, done_Out=0, and count_OutBUS=0, independent of the clock.
REQ-025 Reset asserted mid-COUNT SHALL abandon the delay with no done pulse.
REQ-026 After reset deasserts, the first start SHALL behave exactly as in REQ-012.

Configuration
REQ-027 Macro SC_RANDTIMER_RETRIGGER_EN defined: start_In=1 (with abort_In=0) in COUNT SHALL recapture random_InBUS (with 0 replaced by 1), clear the prescaler, and stay in COUNT.
REQ-028 Macro SC_RANDTIMER_RETRIGGER_EN undefined: start_In SHALL be ignored in COUNT.

Structure
REQ-029 The package sc_randtimer_pkg SHALL hold the state-encoding typedef (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and the default-parameter constants.
REQ-030 The prescaler SHALL be a sub-module, sc_randtimer_prescaler, with inputs clock, reset, and clear and a one-cycle tick output.

Verification (PRESCALE overridden to 4)
REQ-031 Reset, then random=3 with start pulsed at E0 -> busy high for 12 cycles; count sequence 3,2,1; done pulses once at E0+12+1.
REQ-032 random=0 with start -> loaded value 1; done pulses 4 cycles after capture.
REQ-033 random=5, then abort asserted at tick 2 -> IDLE next edge; busy=0; count=0; no done pulse.
REQ-034 Start and abort high together in IDLE -> FSM stays in IDLE; busy remains 0.
REQ-035 Reset pulled low mid-COUNT with random=7 -> all outputs 0 asynchronously; no done pulse after release.
REQ-036 Retrigger: random=6, start again at tick 2 with random=2 -> with the macro, done 8 cycles after the retrigger; without the macro, done at E0+24+1.
